// File: rtl/nanov_spi_pkg.sv
// Shared command codes, FSM states and transfer-direction flag for the nanoV SPI memory responder.
package nanov_spi_pkg;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

    localparam logic [4:0] CMD_LAST  = 5'd7;
    localparam logic [4:0] ADDR_LAST = 5'd23;
    localparam logic [4:0] BYTE_LAST = 5'd7;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        READ,
        WRITE,
        IGNORE
    } spi_state_e;

    // Remembers which command opened the address phase.
    typedef enum logic {
        XFER_READ,
        XFER_WRITE
    } xfer_dir_e;

endpackage

// File: rtl/nanov_spi_byte_mem.sv
// Byte array with an SPI port and a host backdoor port; both read asynchronously, write on posedge.
module nanov_spi_byte_mem #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] spi_addr,
    input  logic                 spi_we,
    input  logic [7:0]           spi_wdata,
    output logic [7:0]           spi_rdata,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic                 host_we,
    input  logic [7:0]           host_wdata,
    output logic [7:0]           host_rdata
);

    logic [7:0] mem [2**ADDR_BITS];
    logic       host_commit;

    // A host write that collides with an SPI commit on the same byte is dropped.
    assign host_commit = host_we && !(spi_we && (spi_addr == host_addr));

    always_ff @(posedge clk) begin
        if (host_commit)
            mem[host_addr] <= host_wdata;
        if (spi_we)
            mem[spi_addr] <= spi_wdata;
    end

    assign spi_rdata  = mem[spi_addr];
    assign host_rdata = mem[host_addr];

endmodule

// File: rtl/nanov_spi_mem_responder.sv
// SPI memory responder for the nanoV core: READ/WRITE commands with a 24-bit address into a local byte array.
module nanov_spi_mem_responder
    import nanov_spi_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_select,
    input  logic                 spi_clk_enable,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    input  logic                 host_we,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic [7:0]           host_wdata,
    output logic [7:0]           host_rdata
);

    localparam logic [ADDR_BITS-1:0] PTR_ONE = ADDR_BITS'(1);

    spi_state_e           state, state_nx;
    xfer_dir_e            dir, dir_nx;
    logic [4:0]           cnt, cnt_nx;
    logic [7:0]           shreg, sh_nx, sh_in;
    logic [ADDR_BITS-1:0] ptr, ptr_nx, addr_in, mem_addr;
    logic                 miso_nx, spi_we;
    logic [7:0]           mem_rdata;

    // During ADDR the pointer doubles as the address shift register; only the low bits survive.
    assign sh_in    = {shreg[6:0], spi_mosi};
    assign addr_in  = {ptr[ADDR_BITS-2:0], spi_mosi};
    assign mem_addr = (state == ADDR) ? addr_in : ptr;

    nanov_spi_byte_mem #(.ADDR_BITS(ADDR_BITS)) u_mem (
        .clk        (clk),
        .spi_addr   (mem_addr),
        .spi_we     (spi_we),
        .spi_wdata  (sh_in),
        .spi_rdata  (mem_rdata),
        .host_addr  (host_addr),
        .host_we    (host_we),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dir      <= XFER_READ;
            cnt      <= '0;
            shreg    <= '0;
            ptr      <= '0;
            spi_miso <= 1'b0;
        end else begin
            state    <= state_nx;
            dir      <= dir_nx;
            cnt      <= cnt_nx;
            shreg    <= sh_nx;
            ptr      <= ptr_nx;
            spi_miso <= miso_nx;
        end
    end

    always_comb begin
        state_nx = state;
        dir_nx   = dir;
        cnt_nx   = cnt;
        sh_nx    = shreg;
        ptr_nx   = ptr;
        miso_nx  = spi_miso;
        spi_we   = 1'b0;
        if (spi_select) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            miso_nx  = 1'b0;
        end else if (spi_clk_enable) begin
            miso_nx = 1'b0;
            unique case (state)
                IDLE: begin
                    state_nx = CMD;
                    sh_nx    = sh_in;
                    cnt_nx   = 5'd1;
                end
                CMD: begin
                    sh_nx  = sh_in;
                    cnt_nx = cnt + 5'd1;
                    if (cnt == CMD_LAST) begin
                        cnt_nx = '0;
                        if (sh_in == SPI_CMD_READ) begin
                            state_nx = ADDR;
                            dir_nx   = XFER_READ;
                        end else if (sh_in == SPI_CMD_WRITE) begin
                            state_nx = ADDR;
                            dir_nx   = XFER_WRITE;
                        end else begin
                            state_nx = IGNORE;
                        end
                    end
                end
                ADDR: begin
                    ptr_nx = addr_in;
                    cnt_nx = cnt + 5'd1;
                    if (cnt == ADDR_LAST) begin
                        cnt_nx = '0;
                        if (dir == XFER_READ) begin
                            // Zero dummy cycles: first data bit goes out on the last address edge.
                            state_nx = READ;
                            sh_nx    = mem_rdata;
                            miso_nx  = mem_rdata[7];
                            ptr_nx   = addr_in + PTR_ONE;
                        end else begin
                            state_nx = WRITE;
                        end
                    end
                end
                READ: begin
                    if (cnt == BYTE_LAST) begin
                        cnt_nx  = '0;
                        sh_nx   = mem_rdata;
                        miso_nx = mem_rdata[7];
                        ptr_nx  = ptr + PTR_ONE;
                    end else begin
                        cnt_nx  = cnt + 5'd1;
                        sh_nx   = {shreg[6:0], 1'b0};
                        miso_nx = shreg[6];
                    end
                end
                WRITE: begin
                    sh_nx  = sh_in;
                    cnt_nx = cnt + 5'd1;
                    if (cnt == BYTE_LAST) begin
                        cnt_nx = '0;
                        spi_we = 1'b1;
                        ptr_nx = ptr + PTR_ONE;
                    end
                end
                IGNORE: miso_nx = 1'b0;
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: doc/nanov_spi_mem_responder.md
# nanov_spi_mem_responder

SPI memory responder: the device side of the serial bus the nanoV CPU drives for instruction fetch and load/store. It decodes READ (0x03) and WRITE (0x02) commands with a 24-bit address from an internal byte array and streams data back. It exists so simulation and FPGA builds can run the core without external SPI RAM.

## Interface
Parameters:
- `ADDR_BITS`, 10: byte-array address width. Array size is 2^ADDR_BITS bytes.

Ports:
- `clk`  in  1  single clock, shared with the CPU; all sampling on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `spi_select`  in  1  chip select, active low, from the CPU.
- `spi_clk_enable`  in  1  bus clock gate; the bus advances only on edges where this is 1.
- `spi_mosi`  in  1  serial data from the CPU.
- `spi_miso`  out  1  serial data to the CPU; registered.
- `host_we`  in  1  backdoor byte write, for preload and checking.
- `host_addr`  in  ADDR_BITS  backdoor address.
- `host_wdata`  in  8  backdoor write data.
- `host_rdata`  out  8  combinational read of `mem[host_addr]`.

## Operation
- Bus edge: posedge `clk` with `spi_select`=0 and `spi_clk_enable`=1. On any other edge the responder state and `spi_miso` hold. This covers the CPU pausing the clock between instructions with select held low.
- Posedge with `spi_select`=1: state goes to IDLE, bit counter 0, `spi_miso` 0. A partially received write byte is discarded.
- States:
  - IDLE: wait for select low. The first bus edge enters CMD and captures bit 7.
  - CMD: 8 bits, MSB first. 0x03 goes to ADDR(read). 0x02 goes to ADDR(write). Any other value goes to IGNORE.
  - ADDR: 24 bits, MSB first. Only the low ADDR_BITS bits are kept, so high bits alias.
  - READ: on the last address edge, load shift register with `mem[A]`, drive its MSB, pointer becomes A+1. Each later bus edge shifts left. After every 8th bit, reload from the pointer and increment it.
  - WRITE: shift in bits MSB first. On the 8th bit, write the byte to `mem[ptr]` and increment the pointer.
  - IGNORE: `spi_miso`=0 until select rises.
- The pointer wraps modulo 2^ADDR_BITS, so a read or write past the top continues at 0.
- `spi_miso` is 0 in every state except READ.
- Host port: a write takes effect on posedge. If it hits the same address in the same cycle as an SPI write commit, the SPI write wins.
- Reset does not clear the array.

## Timing
- Reset value: `spi_miso`=0, state IDLE, counter 0, pointer 0.
- Read latency is zero dummy cycles. Data bit 7 of byte A is valid for sampling at the first bus edge after the last address bit edge. Each later bus edge presents the next bit.
- Write commit: the array is updated on the bus edge carrying bit 0 of each byte.
- Command needs 8 bus edges and address needs 24, each counted only when `spi_clk_enable`=1.
- Reset asserted mid-transfer aborts it at once. A write byte in progress is not committed; an already-committed byte stays.
- Select rising and clock-enable changing in the same cycle: select wins.

## Structure
- Package `nanov_spi_pkg` holds:
  - `SPI_CMD_READ`=8'h03 and `SPI_CMD_WRITE`=8'h02.
  - The state enum: IDLE, CMD, ADDR, READ, WRITE, IGNORE.
  - The flag that distinguishes read from write during ADDR.
- Sub-module `nanov_spi_byte_mem` owns the byte array. It has one SPI port (async read, sync write) and one host port (async read, sync write), and applies the SPI-over-host write priority.
- The top level holds the FSM, the 5-bit bit counter, the 8-bit shift register and the pointer.

## Test plan
- Read: preload 0x100..0x103 = 0x13,0x05,0x50,0x00 via host. Send 0x03, 0x000100, then 32 clocks. Expect MISO bits 00010011 00000101 01010000 00000000.
- Paused clock: same read, with `spi_clk_enable`=0 for 5 cycles after bit 13 while select stays low. Expect an identical bit stream with MISO held constant during the pause.
- Write: send 0x02, 0x0003FE, then data 0xAA,0x55,0xC3 with ADDR_BITS=10. Expect `host_rdata` 0xAA at 0x3FE, 0x55 at 0x3FF and 0xC3 at 0x000 (wrap).
- Abort: write command to 0x010, 1 full byte 0x77 then 4 bits of 1111, then select high. Expect 0x010=0x77 and 0x011 unchanged. A following read of 0x010 returns 0x77.
- Bad command and aliasing: command 0x9F then 16 clocks gives MISO all 0. Read of address 0xFF0005 returns `mem[0x005]`.
- Reset: assert `rst` mid-read. Expect `spi_miso`=0 immediately, and the array contents unchanged afterwards.
